// File: rtl/lcd_cmd_issuer.sv
// Command-side driver for LCD_CTRL. It buffers host commands in a FIFO, issues them one
// at a time around busy, and stops for good once a Write completes or the watchdog trips.
module lcd_cmd_issuer #(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [3:0]               in_cmd,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [3:0]               cmd,
   output logic                     cmd_valid,
   input  logic                     busy,
   input  logic                     done,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [CNT_W-1:0]         issued_cnt,
   output logic                     finished,
   output logic                     err_cmd,
   output logic                     err_timeout
);

   localparam int AW   = $clog2(DEPTH);
   localparam int WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, SEND, GUARD, WAIT_DONE, FINISH} state_t;

   state_t          state, state_n;
   logic [3:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     level;
   logic [WD_W-1:0] wd_cnt;
   logic            full, empty, push, store, issue, wd_trip, go_finish;

   assign full      = (level == (AW+1)'(DEPTH));
   assign empty     = (level == '0);
   assign in_ready  = !full && (state != FINISH);
   assign push      = in_valid && in_ready;
   assign store     = push && (in_cmd <= 4'hB);
   assign wd_trip   = busy && (wd_cnt == WD_W'(TIMEOUT - 1)) && (state != FINISH);
   assign go_finish = (done || wd_trip) && (state != FINISH);

   assign fifo_level = level;
   assign finished   = (state == FINISH);

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end

   // Completion and watchdog take priority over any issue in the same cycle.
   always_comb begin
      state_n = state;
      issue   = 1'b0;
      if (go_finish) begin
         state_n = FINISH;
      end else begin
         case (state)
            IDLE: begin
               if (!empty && !busy) begin
                  issue   = 1'b1;
                  state_n = SEND;
               end
            end
            SEND:      state_n = GUARD;
            GUARD:     state_n = (cmd == 4'h0) ? WAIT_DONE : IDLE;
            WAIT_DONE: state_n = WAIT_DONE;
            default:   state_n = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (store) mem[wr_ptr] <= in_cmd;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         cmd         <= '0;
         cmd_valid   <= 1'b0;
         issued_cnt  <= '0;
         err_cmd     <= 1'b0;
         err_timeout <= 1'b0;
         wd_cnt      <= '0;
      end else begin
         cmd_valid <= issue;
         if (issue) begin
            cmd        <= mem[rd_ptr];
            issued_cnt <= issued_cnt + 1'b1;
         end
         // Entering or sitting in FINISH discards whatever is still buffered.
         if (state_n == FINISH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
         end else begin
            wr_ptr <= wr_ptr + AW'(store);
            rd_ptr <= rd_ptr + AW'(issue);
            level  <= level + (AW+1)'(store) - (AW+1)'(issue);
         end
         if (push && (in_cmd > 4'hB)) err_cmd <= 1'b1;
         if (wd_trip) err_timeout <= 1'b1;
         if (!busy)                           wd_cnt <= '0;
         else if (wd_cnt != WD_W'(TIMEOUT))   wd_cnt <= wd_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_lcd_cmd_issuer.sv
// Directed bench for lcd_cmd_issuer: issue latency, busy hold-off, full FIFO,
// write/done completion, error flags and mid-run reset.
module tb_lcd_cmd_issuer;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] in_cmd;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] cmd;
   logic       cmd_valid;
   logic       busy;
   logic       done;
   logic [3:0] fifo_level;
   logic [7:0] issued_cnt;
   logic       finished, err_cmd, err_timeout;

   logic       man_busy = 1'b0;
   logic       model_en = 1'b0;
   int         mcnt = 0;
   int         cyc = 0;
   int         log_cmd[$];
   int         log_cyc[$];
   int         errors = 0;
   int         checks = 0;

   assign busy = man_busy | (mcnt != 0);

   lcd_cmd_issuer #(.DEPTH(8), .TIMEOUT(16), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .in_cmd(in_cmd), .in_valid(in_valid), .in_ready(in_ready),
      .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .done(done), .fifo_level(fifo_level),
      .issued_cnt(issued_cnt), .finished(finished), .err_cmd(err_cmd), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   // LCD model: busy rises the cycle after a strobe and stays high for 10 cycles.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cmd_valid === 1'b1) begin
         log_cmd.push_back(int'(cmd));
         log_cyc.push_back(cyc);
      end
      if (model_en && cmd_valid === 1'b1) mcnt <= 10;
      else if (mcnt != 0)                 mcnt <= mcnt - 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] c);
      in_cmd   = c;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0; in_cmd = 4'h0; in_valid = 1'b0; done = 1'b0;
      tick(); tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_issued", issued_cnt, 0);
      chk("rst_flags", {finished, err_cmd, err_timeout}, 0);
      chk("rst_cmd", cmd, 0);
      reset = 1'b1;
      tick();
      chk("idle_empty_no_strobe", cmd_valid, 0);

      // basic issue
      push(4'h5);
      chk("basic_level1", fifo_level, 1);
      chk("basic_no_strobe_yet", cmd_valid, 0);
      tick();
      chk("basic_strobe", cmd_valid, 1);
      chk("basic_cmd", cmd, 5);
      chk("basic_issued", issued_cnt, 1);
      chk("basic_level0", fifo_level, 0);
      tick();
      chk("basic_strobe_drop", cmd_valid, 0);
      chk("basic_cmd_hold", cmd, 5);
      tick(); tick();

      // busy hold-off
      log_cmd.delete(); log_cyc.delete();
      model_en = 1'b1;
      push(4'h1); push(4'h2); push(4'h3);
      repeat (45) tick();
      model_en = 1'b0;
      chk("hold_count", log_cmd.size(), 3);
      if (log_cmd.size() == 3) begin
         for (int i = 0; i < 3; i++) chk($sformatf("hold_order%0d", i), log_cmd[i], i + 1);
         chk("hold_gap01", log_cyc[1] - log_cyc[0], 12);
         chk("hold_gap12", log_cyc[2] - log_cyc[1], 12);
      end
      chk("hold_issued", issued_cnt, 4);

      // full FIFO, then simultaneous push/pop
      man_busy = 1'b1;
      for (int i = 1; i <= 8; i++) push(4'(i));
      chk("full_level", fifo_level, 8);
      chk("full_in_ready", in_ready, 0);
      in_cmd = 4'h9; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("full_ignore", fifo_level, 8);
      log_cmd.delete(); log_cyc.delete();
      man_busy = 1'b0;
      tick();
      chk("full_pop_level", fifo_level, 7);
      chk("full_pop_cmd", cmd, 1);
      tick(); tick();
      push(4'h9);
      chk("simul_level", fifo_level, 7);
      chk("simul_strobe", cmd_valid, 1);
      chk("simul_cmd", cmd, 2);
      push(4'hA);
      chk("push_only_level", fifo_level, 8);
      repeat (40) tick();
      chk("drain_count", log_cmd.size(), 10);
      if (log_cmd.size() == 10)
         for (int i = 0; i < 10; i++) chk($sformatf("drain_order%0d", i), log_cmd[i], i + 1);
      chk("drain_level", fifo_level, 0);
      chk("drain_issued", issued_cnt, 14);

      // write / done
      log_cmd.delete(); log_cyc.delete();
      push(4'h7); push(4'h0); push(4'h4);
      repeat (20) tick();
      chk("wd_level", fifo_level, 1);
      chk("wd_not_finished", finished, 0);
      chk("wd_no_strobe", cmd_valid, 0);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("fin_finished", finished, 1);
      chk("fin_in_ready", in_ready, 0);
      chk("fin_level", fifo_level, 0);
      in_cmd = 4'h3; in_valid = 1'b1;
      tick(); tick();
      in_valid = 1'b0;
      chk("fin_no_push", fifo_level, 0);
      chk("fin_cmd_valid", cmd_valid, 0);
      chk("fin_log_count", log_cmd.size(), 2);
      if (log_cmd.size() == 2) begin
         chk("fin_log0", log_cmd[0], 7);
         chk("fin_log1", log_cmd[1], 0);
      end
      chk("fin_issued", issued_cnt, 16);
      chk("fin_no_timeout", err_timeout, 0);

      // errors
      reset = 1'b0; tick(); reset = 1'b1;
      chk("rst2_finished", finished, 0);
      man_busy = 1'b1;
      push(4'h3);
      push(4'hE);
      chk("errcmd_flag", err_cmd, 1);
      chk("errcmd_level", fifo_level, 1);
      repeat (13) tick();
      chk("wdog_before", err_timeout, 0);
      chk("wdog_before_fin", finished, 0);
      tick();
      chk("wdog_flag", err_timeout, 1);
      chk("wdog_finished", finished, 1);
      chk("wdog_level", fifo_level, 0);
      chk("wdog_errcmd_sticky", err_cmd, 1);

      // reset mid-run
      man_busy = 1'b0;
      reset = 1'b0; tick(); reset = 1'b1;
      man_busy = 1'b1;
      push(4'h1); push(4'h2); push(4'h3); push(4'h4);
      man_busy = 1'b0;
      tick();
      chk("mid_strobe", cmd_valid, 1);
      chk("mid_level", fifo_level, 3);
      reset = 1'b0;
      tick();
      chk("mid_rst_strobe", cmd_valid, 0);
      chk("mid_rst_level", fifo_level, 0);
      chk("mid_rst_issued", issued_cnt, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_flags", {finished, err_cmd, err_timeout}, 0);
      reset = 1'b1;
      push(4'h6);
      tick();
      chk("post_rst_strobe", cmd_valid, 1);
      chk("post_rst_cmd", cmd, 6);
      chk("post_rst_issued", issued_cnt, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
